// File: rtl/vk_pkg.sv
// Shared types and defaults for the video/key memory arbiter.
package vk_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] KEY_ADDR_DEF = 32'h0000_20D0;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_KEY,
        OWN_CPU
    } owner_e;

endpackage

// File: rtl/vk_key_fifo.sv
// Small synchronous FIFO for keyboard codes; a pop lets a push at full succeed.
module vk_key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vk_mem_arbiter.sv
// Single-port vk memory arbiter: VGA reads, buffered keyboard mailbox writes, CPU access.
module vk_mem_arbiter
    import vk_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter logic [31:0] KEY_ADDR = KEY_ADDR_DEF,
    parameter int          KQ_DEPTH = 4,
    parameter int          STARVE   = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              key_valid,
    input  logic [7:0]        key_data,
    output logic              key_overflow,
    input  logic              key_ovf_clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int KA = $clog2(KQ_DEPTH);
    localparam int SW = $clog2(STARVE + 1);

    owner_e        owner;
    logic [7:0]    key_head;
    logic          key_full;
    logic          key_empty;
    logic [KA:0]   key_count;
    logic [SW-1:0] starve_cnt;
    logic          starve_hit;
    logic          key_drop;

    vk_key_fifo #(
        .DEPTH (KQ_DEPTH),
        .W     (8)
    ) u_key_fifo (
        .clk   (sys_clk),
        .rst_n (rst),
        .push  (key_valid),
        .din   (key_data),
        .pop   (owner == OWN_KEY),
        .dout  (key_head),
        .full  (key_full),
        .empty (key_empty),
        .count (key_count)
    );

    assign starve_hit = (starve_cnt >= SW'(STARVE));
    assign key_drop   = key_valid && key_full && (owner != OWN_KEY);

    // Owner is held at idle while reset is asserted so no access leaks out.
    always_comb begin
        owner = OWN_NONE;
        if (!rst)                         owner = OWN_NONE;
        else if (!key_empty && starve_hit) owner = OWN_KEY;
        else if (vga_req)                 owner = OWN_VGA;
        else if (!key_empty)              owner = OWN_KEY;
        else if (cpu_req)                 owner = OWN_CPU;
    end

    always_comb begin
        mem_addr  = '0;
        mem_wren  = 1'b0;
        mem_wdata = '0;
        cpu_gnt   = 1'b0;
        case (owner)
            OWN_KEY: begin
                mem_addr  = ADDR_W'(KEY_ADDR);
                mem_wren  = 1'b1;
                mem_wdata = {{(DATA_W-8){1'b0}}, key_head};
            end
            OWN_VGA: mem_addr = vga_addr;
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wren  = cpu_we;
                mem_wdata = cpu_wdata;
                cpu_gnt   = 1'b1;
            end
            default: ;
        endcase
    end

    assign vga_rdata = mem_rdata;
    assign cpu_rdata = mem_rdata;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            starve_cnt   <= '0;
            key_overflow <= 1'b0;
            vga_rvalid   <= 1'b0;
            cpu_rvalid   <= 1'b0;
        end else begin
            vga_rvalid <= (owner == OWN_VGA);
            cpu_rvalid <= (owner == OWN_CPU) && !cpu_we;
            if (key_empty || owner == OWN_KEY) starve_cnt <= '0;
            else if (!starve_hit)              starve_cnt <= starve_cnt + SW'(1);
            // A drop in the same cycle as a clear keeps the flag set.
            if (key_drop)         key_overflow <= 1'b1;
            else if (key_ovf_clr) key_overflow <= 1'b0;
        end
    end

    a_count_consistent: assert property (@(posedge sys_clk) disable iff (!rst)
        key_empty == (key_count == '0));

endmodule

// File: tb/tb_vk_mem_arbiter.sv
// Bench for vk_mem_arbiter: scenario tasks plus a cycle-level reference model of the arbitration rules.
module tb_vk_mem_arbiter;

    localparam int          STARVE   = 8;
    localparam int          KQ_DEPTH = 4;
    localparam logic [31:0] KEY_ADDR = 32'h0000_20D0;
    localparam int          KEY_IDX  = 32'h20D0 % 16384;

    logic        sys_clk;
    logic        rst;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_rvalid;
    logic [31:0] vga_rdata;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        key_overflow;
    logic        key_ovf_clr;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic [31:0] mem_addr;
    logic        mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors;
    int miscompares;

    vk_mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .KEY_ADDR (KEY_ADDR),
        .KQ_DEPTH (KQ_DEPTH),
        .STARVE   (STARVE)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_rvalid   (vga_rvalid),
        .vga_rdata    (vga_rdata),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_overflow (key_overflow),
        .key_ovf_clr  (key_ovf_clr),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .mem_addr     (mem_addr),
        .mem_wren     (mem_wren),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // ---------------- clock / memory ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [31:0] phys    [16384];
    logic [31:0] ref_mem [16384];

    initial mem_rdata = '0;
    always @(posedge sys_clk) begin
        if (mem_wren) phys[mem_addr[13:0]] <= mem_wdata;
        mem_rdata <= phys[mem_addr[13:0]];
    end

    // ---------------- reference model ----------------
    // Owner codes: 0 idle, 1 vga, 2 key, 3 cpu.
    logic [7:0]  kq[$];
    int          wait_n;
    bit          m_ovf;
    bit          p_vga;
    bit          p_cpu;
    logic [31:0] p_vga_d;
    logic [31:0] p_cpu_d;

    always @(negedge sys_clk) begin
        int          own;
        bit          have;
        bit          set_ovf;
        logic        e_wren;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        if (!rst) begin
            vectors++;
            if ({mem_wren, cpu_gnt, vga_rvalid, cpu_rvalid, key_overflow} !== 5'b0 ||
                mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                miscompares++;
                $display("FAIL mon_reset t=%0t got wren=%b gnt=%b vrv=%b crv=%b ovf=%b addr=%h wdata=%h exp all zero",
                         $time, mem_wren, cpu_gnt, vga_rvalid, cpu_rvalid, key_overflow, mem_addr, mem_wdata);
            end
            kq.delete();
            wait_n = 0;
            m_ovf  = 0;
            p_vga  = 0;
            p_cpu  = 0;
        end else begin
            have = (kq.size() > 0);
            if (have && wait_n >= STARVE) own = 2;
            else if (vga_req)             own = 1;
            else if (have)                own = 2;
            else if (cpu_req)             own = 3;
            else                          own = 0;
            e_wren = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
            if (own == 2) begin e_wren = 1'b1; e_addr = KEY_ADDR; e_wdata = {24'h0, kq[0]}; end
            if (own == 1) e_addr = vga_addr;
            if (own == 3) begin e_wren = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata; end

            vectors++;
            if (mem_wren !== e_wren || mem_addr !== e_addr || mem_wdata !== e_wdata || cpu_gnt !== (own == 3)) begin
                miscompares++;
                $display("FAIL mon_access t=%0t got wren=%b addr=%h wdata=%h gnt=%b exp wren=%b addr=%h wdata=%h gnt=%b",
                         $time, mem_wren, mem_addr, mem_wdata, cpu_gnt, e_wren, e_addr, e_wdata, own == 3);
            end
            vectors++;
            if (vga_rvalid !== p_vga || (p_vga && vga_rdata !== p_vga_d)) begin
                miscompares++;
                $display("FAIL mon_vga_read t=%0t got rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                         $time, vga_rvalid, vga_rdata, p_vga, p_vga_d);
            end
            vectors++;
            if (cpu_rvalid !== p_cpu || (p_cpu && cpu_rdata !== p_cpu_d)) begin
                miscompares++;
                $display("FAIL mon_cpu_read t=%0t got rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                         $time, cpu_rvalid, cpu_rdata, p_cpu, p_cpu_d);
            end
            vectors++;
            if (key_overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL mon_overflow t=%0t got %b exp %b", $time, key_overflow, m_ovf);
            end

            // advance the model across the coming edge
            if (own == 2) begin
                ref_mem[KEY_IDX] = {24'h0, kq[0]};
                void'(kq.pop_front());
                wait_n = 0;
            end else if (have) begin
                wait_n++;
            end
            if (kq.size() == 0) wait_n = 0;
            set_ovf = 0;
            if (key_valid) begin
                if (kq.size() < KQ_DEPTH) kq.push_back(key_data);
                else set_ovf = 1;
            end
            if (set_ovf) m_ovf = 1;
            else if (key_ovf_clr) m_ovf = 0;
            p_vga = (own == 1);
            if (p_vga) p_vga_d = ref_mem[vga_addr[13:0]];
            p_cpu = (own == 3) && !cpu_we;
            if (p_cpu) p_cpu_d = ref_mem[cpu_addr[13:0]];
            if (own == 3 && cpu_we) ref_mem[cpu_addr[13:0]] = cpu_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        vga_req = 0; vga_addr = 0; key_valid = 0; key_data = 0; key_ovf_clr = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        vga_req = 1; cpu_req = 1; key_valid = 1; key_data = 8'h33;
        repeat (2) begin
            @(negedge sys_clk);
            vectors++;
            if (mem_wren !== 0 || cpu_gnt !== 0 || mem_addr !== 0 || mem_wdata !== 0 || vga_rvalid !== 0 || cpu_rvalid !== 0) begin
                miscompares++;
                $display("FAIL reset_hold got wren=%b gnt=%b addr=%h wdata=%h vrv=%b crv=%b exp zeros",
                         mem_wren, cpu_gnt, mem_addr, mem_wdata, vga_rvalid, cpu_rvalid);
            end
        end
        tick();
        idle_inputs();
        rst = 1;
        @(negedge sys_clk);
        vectors++;
        if (mem_wren !== 0 || mem_addr !== 0 || mem_wdata !== 0 || key_overflow !== 0 || cpu_gnt !== 0) begin
            miscompares++;
            $display("FAIL reset_idle got wren=%b addr=%h wdata=%h ovf=%b gnt=%b exp zeros",
                     mem_wren, mem_addr, mem_wdata, key_overflow, cpu_gnt);
        end
    endtask

    task automatic test_first_key();
        tick();
        key_valid = 1; key_data = 8'h41;
        tick();
        key_valid = 0;
        @(negedge sys_clk);
        vectors++;
        if (mem_wren !== 1 || mem_addr !== 32'h20D0 || mem_wdata !== 32'h41) begin
            miscompares++;
            $display("FAIL first_key got wren=%b addr=%h wdata=%h exp 1 000020d0 00000041", mem_wren, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_vga_seq();
        tick();
        for (int i = 0; i < 4; i++) begin
            vga_req = 1; vga_addr = i;
            @(negedge sys_clk);
            vectors++;
            if (mem_addr !== i || mem_wren !== 0) begin
                miscompares++;
                $display("FAIL vga_addr got addr=%h wren=%b exp %h 0", mem_addr, mem_wren, i);
            end
            if (i > 0) begin
                vectors++;
                if (vga_rvalid !== 1 || vga_rdata !== ref_mem[i-1]) begin
                    miscompares++;
                    $display("FAIL vga_data got rvalid=%b rdata=%h exp 1 %h", vga_rvalid, vga_rdata, ref_mem[i-1]);
                end
            end
            tick();
        end
        vga_req = 0;
        @(negedge sys_clk);
        vectors++;
        if (vga_rvalid !== 1 || vga_rdata !== ref_mem[3]) begin
            miscompares++;
            $display("FAIL vga_last got rvalid=%b rdata=%h exp 1 %h", vga_rvalid, vga_rdata, ref_mem[3]);
        end
    endtask

    task automatic test_starve();
        int          found;
        logic [31:0] wd;
        tick();
        vga_req = 1; vga_addr = $urandom_range(0, 1023);
        key_valid = 1; key_data = 8'h5A;
        tick();
        key_valid = 0;
        found = -1;
        wd = 0;
        for (int j = 0; j < 30 && found < 0; j++) begin
            @(negedge sys_clk);
            if (mem_wren === 1'b1) begin
                found = j;
                wd = mem_wdata;
            end else begin
                tick();
            end
        end
        vectors++;
        if (found != STARVE || wd !== 32'h5A) begin
            miscompares++;
            $display("FAIL starve_delay got cycle=%0d wdata=%h exp cycle=%0d wdata=0000005a", found, wd, STARVE);
        end
        tick();
        @(negedge sys_clk);
        vectors++;
        if (vga_rvalid !== 0) begin
            miscompares++;
            $display("FAIL starve_hole got rvalid=%b exp 0", vga_rvalid);
        end
        tick();
        vga_req = 0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        tick();
        vga_req = 1; vga_addr = $urandom_range(0, 1023);
        for (int i = 0; i < 5; i++) begin
            key_valid = 1;
            key_data = 8'($urandom_range(1, 255));
            exp_q.push_back(key_data);
            tick();
        end
        key_valid = 0;
        @(negedge sys_clk);
        vectors++;
        if (key_overflow !== 1) begin
            miscompares++;
            $display("FAIL ovf_set got %b exp 1", key_overflow);
        end
        for (int j = 0; j < 60; j++) begin
            tick();
            @(negedge sys_clk);
            if (mem_wren === 1'b1) got_q.push_back(mem_wdata[7:0]);
        end
        vectors++;
        if (got_q.size() != KQ_DEPTH) begin
            miscompares++;
            $display("FAIL ovf_count got %0d writes exp %0d", got_q.size(), KQ_DEPTH);
        end
        for (int k = 0; k < got_q.size() && k < KQ_DEPTH; k++) begin
            vectors++;
            if (got_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL ovf_order idx=%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        vectors++;
        if (key_overflow !== 1) begin
            miscompares++;
            $display("FAIL ovf_sticky got %b exp 1", key_overflow);
        end
        tick();
        key_ovf_clr = 1;
        tick();
        key_ovf_clr = 0;
        @(negedge sys_clk);
        vectors++;
        if (key_overflow !== 0) begin
            miscompares++;
            $display("FAIL ovf_clear got %b exp 0", key_overflow);
        end
        vga_req = 0;
    endtask

    task automatic test_cpu();
        logic [31:0] wv;
        logic [31:0] rv;
        tick();
        vga_req = 1; vga_addr = $urandom_range(0, 1023);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        rv = ref_mem[32'h100];
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            vectors++;
            if (cpu_gnt !== 0) begin
                miscompares++;
                $display("FAIL cpu_blocked got gnt=%b exp 0", cpu_gnt);
            end
            tick();
        end
        vga_req = 0;
        @(negedge sys_clk);
        vectors++;
        if (cpu_gnt !== 1 || mem_addr !== 32'h100 || mem_wren !== 0) begin
            miscompares++;
            $display("FAIL cpu_read_gnt got gnt=%b addr=%h wren=%b exp 1 00000100 0", cpu_gnt, mem_addr, mem_wren);
        end
        tick();
        cpu_req = 0;
        @(negedge sys_clk);
        vectors++;
        if (cpu_rvalid !== 1 || cpu_rdata !== rv) begin
            miscompares++;
            $display("FAIL cpu_read_data got rvalid=%b rdata=%h exp 1 %h", cpu_rvalid, cpu_rdata, rv);
        end
        tick();
        wv = $urandom;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h104; cpu_wdata = wv;
        @(negedge sys_clk);
        vectors++;
        if (cpu_gnt !== 1 || mem_wren !== 1 || mem_addr !== 32'h104 || mem_wdata !== wv) begin
            miscompares++;
            $display("FAIL cpu_write got gnt=%b wren=%b addr=%h wdata=%h exp 1 1 00000104 %h",
                     cpu_gnt, mem_wren, mem_addr, mem_wdata, wv);
        end
        tick();
        cpu_we = 0; cpu_wdata = 0;
        @(negedge sys_clk);
        tick();
        cpu_req = 0;
        @(negedge sys_clk);
        vectors++;
        if (cpu_rvalid !== 1 || cpu_rdata !== wv) begin
            miscompares++;
            $display("FAIL cpu_readback got rvalid=%b rdata=%h exp 1 %h", cpu_rvalid, cpu_rdata, wv);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        vga_req = 1; vga_addr = 5;
        key_valid = 1; key_data = 8'h11;
        tick();
        key_data = 8'h22;
        tick();
        key_valid = 0;
        tick();
        rst = 0;
        @(negedge sys_clk);
        vectors++;
        if (vga_rvalid !== 0) begin
            miscompares++;
            $display("FAIL midrst_rvalid got %b exp 0", vga_rvalid);
        end
        tick();
        vga_req = 0;
        tick();
        rst = 1;
        for (int j = 0; j < 20; j++) begin
            @(negedge sys_clk);
            vectors++;
            if (mem_wren !== 0 || vga_rvalid !== 0) begin
                miscompares++;
                $display("FAIL midrst_quiet cycle=%0d got wren=%b rvalid=%b exp 0 0", j, mem_wren, vga_rvalid);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic g;
        for (int n = 0; n < 600; n++) begin
            @(negedge sys_clk);
            g = cpu_gnt;
            tick();
            vga_req     = ($urandom_range(0, 9) < 5);
            vga_addr    = $urandom_range(0, 1023);
            key_valid   = ($urandom_range(0, 5) == 0);
            key_data    = 8'($urandom_range(1, 255));
            key_ovf_clr = ($urandom_range(0, 15) == 0);
            if (cpu_req && g) begin
                cpu_req = 0;
            end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req   = 1;
                cpu_we    = $urandom_range(0, 1);
                cpu_addr  = $urandom_range(0, 1023);
                cpu_wdata = $urandom;
            end
        end
        idle_inputs();
        repeat (60) tick();
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 16384; i++) begin
            phys[i]    = $urandom;
            ref_mem[i] = phys[i];
        end
        test_reset();
        test_first_key();
        test_vga_seq();
        test_starve();
        test_overflow();
        test_cpu();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
